// File: rtl/cover_counter_scan.sv
// rtl/cover_counter_scan.sv - per-point saturating cover-hit counters with snapshot readout
// over a valid/ready word stream.
module cover_counter_scan #(
  parameter int N_COVERS      = 4,
  parameter int WIDTH         = 8,
  parameter bit CLEAR_ON_READ = 1'b1,
  localparam int IDX_W        = (N_COVERS > 1) ? $clog2(N_COVERS) : 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [N_COVERS-1:0] cover_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WIDTH-1:0]    out_data_o,
  output logic [IDX_W-1:0]    out_index_o,
  output logic                out_last_o
);

  typedef enum logic {ST_IDLE, ST_READ} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] cnt_q    [N_COVERS];
  logic [WIDTH-1:0] cnt_d    [N_COVERS];
  logic [WIDTH-1:0] shadow_q [N_COVERS];
  logic [WIDTH-1:0] shadow_d [N_COVERS];

  logic snap;
  logic xfer;
  logic at_last;

  assign at_last = (idx_q == IDX_W'(N_COVERS - 1));
  assign snap    = (state_q == ST_IDLE) && start_i;
  assign xfer    = (state_q == ST_READ) && out_ready_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: begin
        if (xfer) begin
          if (at_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Data is gated by state so the stream reads zero whenever nothing is presented.
  always_comb begin
    busy_o      = (state_q == ST_READ);
    out_valid_o = (state_q == ST_READ);
    out_last_o  = (state_q == ST_READ) && at_last;
    out_index_o = idx_q;
    out_data_o  = (state_q == ST_READ) ? shadow_q[idx_q] : '0;
  end

  // A hit coinciding with a clearing snapshot seeds the fresh count so it is not lost.
  always_comb begin
    for (int i = 0; i < N_COVERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (snap && CLEAR_ON_READ) begin
        cnt_d[i] = (en_i && cover_i[i]) ? WIDTH'(1) : '0;
      end else if (en_i && cover_i[i] && (cnt_q[i] != {WIDTH{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_COVERS; i++) begin
      shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_COVERS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_COVERS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cover_counter_scan.sv
// tb/tb_cover_counter_scan.sv - directed scoreboard bench for cover_counter_scan
// (default, WIDTH=2 and no-clear instances share stimulus, each has its own start).
module tb_cover_counter_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] cov = '0;
  logic       out_ready = 1'b0;
  logic       m_start = 1'b0, s_start = 1'b0, n_start = 1'b0;

  logic       m_busy, m_valid, m_last;
  logic [7:0] m_data;
  logic [1:0] m_idx;
  logic       s_busy, s_valid, s_last;
  logic [1:0] s_data;
  logic [1:0] s_idx;
  logic       n_busy, n_valid, n_last;
  logic [7:0] n_data;
  logic [1:0] n_idx;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q_m[$], q_s[$], q_n[$];

  always #5 clk = ~clk;

  cover_counter_scan #(.N_COVERS(4), .WIDTH(8), .CLEAR_ON_READ(1'b1)) u_main (
    .clock_i(clk), .reset_i(rst), .en_i(en), .cover_i(cov), .start_i(m_start),
    .busy_o(m_busy), .out_valid_o(m_valid), .out_ready_i(out_ready),
    .out_data_o(m_data), .out_index_o(m_idx), .out_last_o(m_last));

  cover_counter_scan #(.N_COVERS(4), .WIDTH(2), .CLEAR_ON_READ(1'b1)) u_sat (
    .clock_i(clk), .reset_i(rst), .en_i(en), .cover_i(cov), .start_i(s_start),
    .busy_o(s_busy), .out_valid_o(s_valid), .out_ready_i(out_ready),
    .out_data_o(s_data), .out_index_o(s_idx), .out_last_o(s_last));

  cover_counter_scan #(.N_COVERS(4), .WIDTH(8), .CLEAR_ON_READ(1'b0)) u_nc (
    .clock_i(clk), .reset_i(rst), .en_i(en), .cover_i(cov), .start_i(n_start),
    .busy_o(n_busy), .out_valid_o(n_valid), .out_ready_i(out_ready),
    .out_data_o(n_data), .out_index_o(n_idx), .out_last_o(n_last));

  function automatic logic [31:0] pk(input int idx, input int data, input logic last);
    return {15'd0, idx[7:0], data[7:0], last};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic collect();
    logic [31:0] e;
    if (!rst && m_valid && out_ready) begin
      chk("main_word_expected", 32'(q_m.size() != 0), 1);
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("main_word", pk(m_idx, m_data, m_last), e);
      end
    end
    if (!rst && s_valid && out_ready) begin
      chk("sat_word_expected", 32'(q_s.size() != 0), 1);
      if (q_s.size() != 0) begin
        e = q_s.pop_front();
        chk("sat_word", pk(s_idx, s_data, s_last), e);
      end
    end
    if (!rst && n_valid && out_ready) begin
      chk("noclr_word_expected", 32'(q_n.size() != 0), 1);
      if (q_n.size() != 0) begin
        e = q_n.pop_front();
        chk("noclr_word", pk(n_idx, n_data, n_last), e);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    collect();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int which, input int d0, input int d1, input int d2, input int d3);
    logic [31:0] w [4];
    w[0] = pk(0, d0, 1'b0);
    w[1] = pk(1, d1, 1'b0);
    w[2] = pk(2, d2, 1'b0);
    w[3] = pk(3, d3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      case (which)
        0:       q_m.push_back(w[k]);
        1:       q_s.push_back(w[k]);
        default: q_n.push_back(w[k]);
      endcase
    end
  endtask

  task automatic run_readout(input int which);
    out_ready = 1'b1;
    case (which)
      0:       m_start = 1'b1;
      1:       s_start = 1'b1;
      default: n_start = 1'b1;
    endcase
    step();
    m_start = 1'b0;
    s_start = 1'b0;
    n_start = 1'b0;
    repeat (4) step();
    case (which)
      0: begin
        chk("main_drained", q_m.size(), 0);
        chk("main_busy_after", m_busy, 0);
      end
      1: begin
        chk("sat_drained", q_s.size(), 0);
        chk("sat_busy_after", s_busy, 0);
      end
      default: begin
        chk("noclr_drained", q_n.size(), 0);
        chk("noclr_busy_after", n_busy, 0);
      end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    cov = '0;
    out_ready = 1'b0;
    m_start = 1'b0;
    s_start = 1'b0;
    n_start = 1'b0;
    q_m.delete();
    q_s.delete();
    q_n.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy", m_busy, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_idx, 0);
    chk("rst_last", m_last, 0);
    chk("rst_sat_valid", s_valid, 0);
    chk("rst_noclr_valid", n_valid, 0);

    // Counting and readout with exact cycle timing
    en = 1'b1;
    cov = 4'b0101;
    repeat (3) step();
    cov = '0;
    push4(0, 3, 0, 3, 0);
    out_ready = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    chk("t1_busy_first", m_busy, 1);
    chk("t1_valid_first", m_valid, 1);
    chk("t1_index_first", m_idx, 0);
    repeat (3) step();
    chk("t1_last_word_idx", m_idx, 3);
    chk("t1_last_flag", m_last, 1);
    chk("t1_busy_last", m_busy, 1);
    step();
    chk("t1_busy_end", m_busy, 0);
    chk("t1_valid_end", m_valid, 0);
    chk("t1_drained", q_m.size(), 0);
    push4(0, 0, 0, 0, 0);
    run_readout(0);

    // Saturation at WIDTH=2
    do_reset();
    en = 1'b1;
    cov = 4'b0010;
    repeat (10) step();
    cov = '0;
    push4(1, 0, 3, 0, 0);
    run_readout(1);

    // Backpressure
    do_reset();
    en = 1'b1;
    cov = 4'b0111;
    step();
    cov = 4'b0110;
    step();
    cov = 4'b0100;
    step();
    cov = '0;
    push4(0, 1, 2, 3, 0);
    out_ready = 1'b0;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    repeat (5) begin
      chk("bp_valid_hold", m_valid, 1);
      chk("bp_index_hold", m_idx, 0);
      chk("bp_data_hold", m_data, 1);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 2 == 0);
      step();
    end
    chk("bp_drained", q_m.size(), 0);
    chk("bp_busy_after", m_busy, 0);

    // Hit coincident with snapshot; start during READ is ignored
    do_reset();
    en = 1'b1;
    cov = 4'b0100;
    repeat (5) step();
    push4(0, 0, 0, 5, 0);
    m_start = 1'b1;
    step();
    cov = '0;
    repeat (3) step();
    m_start = 1'b0;
    chk("sim_still_idx0", m_idx, 0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("sim_drained", q_m.size(), 0);
    chk("sim_not_requeued", m_busy, 0);
    push4(0, 0, 0, 1, 0);
    run_readout(0);

    // Enable low blocks counting
    do_reset();
    en = 1'b0;
    cov = 4'hF;
    repeat (4) step();
    cov = '0;
    en = 1'b1;
    push4(0, 0, 0, 0, 0);
    run_readout(0);

    // No clear on read: counts accumulate across readouts
    do_reset();
    en = 1'b1;
    cov = 4'b0001;
    repeat (2) step();
    cov = '0;
    push4(2, 2, 0, 0, 0);
    run_readout(2);
    cov = 4'b0001;
    repeat (2) step();
    cov = '0;
    push4(2, 4, 0, 0, 0);
    run_readout(2);

    // Asynchronous reset mid-readout
    do_reset();
    en = 1'b1;
    cov = 4'hF;
    repeat (2) step();
    cov = '0;
    push4(0, 2, 2, 2, 2);
    out_ready = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    step();
    step();
    chk("mid_index_before", m_idx, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_index", m_idx, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_abandoned_words", q_m.size(), 2);
    q_m.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_no_resume", m_valid, 0);
    push4(0, 0, 0, 0, 0);
    run_readout(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
